multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle fetch/decode/exec/mem/wb controller with retire counter
// Define ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multicycle_control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        mem_ready,
  output logic [2:0]  imm_src,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic [15:0] retired_count,
  output logic        illegal
);

  localparam logic [6:0] OP_R_ALU = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
    , ST_TRAP = 3'd5
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_R_ALU,
    CLS_I_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } cls_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [2:0]  imm_src_q, imm_src_d;
  logic [15:0] retired_count_q, retired_count_d;
  cls_e        cls;
  logic        retire;
  logic        unused_ir_bits;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Only the opcode field steers control; the rest of IR belongs to the datapath.
  assign unused_ir_bits = ^ir_q[31:7];

  always_comb begin
    cls = CLS_ILLEGAL;
    case (ir_q[6:0])
      OP_R_ALU: cls = CLS_R_ALU;
      OP_I_ALU: cls = CLS_I_ALU;
      OP_LOAD:  cls = CLS_LOAD;
      OP_STORE: cls = CLS_STORE;
      default:  cls = CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    imm_src_d       = imm_src_q;
    retired_count_d = retired_count_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d       = illegal_q;
`endif
    instr_ready = 1'b0;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_write    = 1'b0;
    retire      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d      = instruction;
          imm_src_d = (instruction[6:0] == OP_STORE) ? 3'b001 : 3'b000;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls != CLS_ILLEGAL) begin
          state_d = ST_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
`else
          state_d   = ST_WB;
`endif
        end
      end
      ST_EXEC: begin
        alu_src = (cls != CLS_R_ALU);
        state_d = (cls == CLS_LOAD || cls == CLS_STORE) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_read  = (cls == CLS_LOAD);
        mem_write = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_WB;
          end
        end
      end
      ST_WB: begin
        // Illegal opcodes reach WB only as NOPs: advance PC without a register write.
        reg_write = (cls != CLS_ILLEGAL);
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (retire) begin
      retired_count_d = retired_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_FETCH;
      ir_q            <= 32'd0;
      imm_src_q       <= 3'b000;
      retired_count_q <= 16'd0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      ir_q            <= ir_d;
      imm_src_q       <= imm_src_d;
      retired_count_q <= retired_count_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q       <= illegal_d;
`endif
    end
  end

  assign imm_src       = imm_src_q;
  assign retired_count = retired_count_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal       = illegal_q;
`else
  assign illegal       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_ready;
  logic [2:0]  imm_src;
  logic        alu_src;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic [15:0] retired_count;
  logic        illegal;

  int checks = 0;
  int passes = 0;

  multicycle_control_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .mem_ready     (mem_ready),
    .imm_src       (imm_src),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .pc_write      (pc_write),
    .retired_count (retired_count),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_ILL = 4;

  function automatic int kind_of(input logic [31:0] instr);
    case (instr[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] w;
    w = $urandom;
    case (kind)
      K_R:     w[6:0] = 7'b0110011;
      K_I:     w[6:0] = 7'b0010011;
      K_LOAD:  w[6:0] = 7'b0000011;
      K_STORE: w[6:0] = 7'b0100011;
      default: begin
        w[6:0] = 7'($urandom_range(0, 127));
        while (kind_of(w) != K_ILL) w[6:0] = 7'($urandom_range(0, 127));
      end
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passes++;
  endtask

  // Runs one instruction from FETCH (called at a negedge) to its retirement; waits = mem_ready-low cycles in MEM.
  task automatic run_instr(input logic [31:0] instr, input int waits);
    int kind, exp_lat, exp_rw, exp_mr, exp_mw, exp_alu, got_lat;
    int rw, mr, mw, pc, ovl, rdy_bad, imm_bad, got_alu, c;
    logic [15:0] start_cnt, exp_cnt;
    logic [2:0]  exp_imm;
    bit done;
    kind    = kind_of(instr);
    exp_imm = (kind == K_STORE) ? 3'b001 : 3'b000;
    exp_alu = (kind == K_R) ? 0 : 1;
    exp_mr  = (kind == K_LOAD)  ? waits + 1 : 0;
    exp_mw  = (kind == K_STORE) ? waits + 1 : 0;
    exp_rw  = (kind == K_STORE || kind == K_ILL) ? 0 : 1;
    case (kind)
      K_LOAD:  exp_lat = 4 + waits;
      K_STORE: exp_lat = 3 + waits;
      K_ILL:   exp_lat = 2;
      default: exp_lat = 3;
    endcase
    start_cnt = retired_count;
    exp_cnt   = start_cnt + 16'd1;
    if (instr_ready !== 1'b1) begin
      checks++;
      $display("FAIL fetch_ready: got %0b expected 1", instr_ready);
    end
    instr_valid = 1'b1;
    instruction = instr;
    mem_ready   = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    rw = 0; mr = 0; mw = 0; pc = 0; ovl = 0; rdy_bad = 0; imm_bad = 0; got_alu = -1;
    got_lat = -1; done = 0; c = 1;
    while (!done && c <= 40) begin
      if (retired_count !== start_cnt) begin
        done    = 1;
        got_lat = c - 1;
      end else begin
        instr_valid = 1'($urandom);
        instruction = $urandom;
        if ((kind == K_LOAD || kind == K_STORE) && c >= 3) mem_ready = (c >= 3 + waits);
        else mem_ready = 1'($urandom);
        #1;
        rw += int'(reg_write); mr += int'(mem_read); mw += int'(mem_write); pc += int'(pc_write);
        if (c == 2 && kind != K_ILL) got_alu = int'(alu_src);
        if (int'(reg_write) + int'(mem_read) + int'(mem_write) > 1) ovl++;
        if (instr_ready !== 1'b0) rdy_bad++;
        if (imm_src !== exp_imm) imm_bad++;
        @(posedge clk);
        @(negedge clk);
        c++;
      end
    end
    instr_valid = 1'b0;
    checks++; if (!done) $display("FAIL retire_timeout: got none expected retire"); else passes++;
    chk("latency", got_lat, exp_lat);
    chk("reg_write_cycles", rw, exp_rw);
    chk("mem_read_cycles", mr, exp_mr);
    chk("mem_write_cycles", mw, exp_mw);
    chk("pc_write_cycles", pc, 1);
    if (kind != K_ILL) chk("alu_src_exec", got_alu, exp_alu);
    chk("strobe_overlap", ovl, 0);
    chk("ready_outside_fetch", rdy_bad, 0);
    chk("imm_src_held", imm_bad, 0);
    chk("retired_count", retired_count, exp_cnt);
    chk("illegal_clear", illegal, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b1; instruction = 32'h00202423; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_strobes", {alu_src, reg_write, mem_read, mem_write, pc_write}, 0);
    chk("rst_imm_src", imm_src, 0);
    chk("rst_count", retired_count, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    run_instr(32'h00500093, 0);
    chk("addi_count", retired_count, 1);
  endtask

  task automatic test_sw();
    run_instr(32'h00202423, 2);
  endtask

  task automatic test_lw();
    run_instr(32'h00402183, 0);
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    logic [15:0] cnt;
    int bad;
    cnt = retired_count;
    instr_valid = 1'b1; instruction = 32'h0000007F;
    @(posedge clk); @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      instr_valid = 1'($urandom); instruction = rand_instr(K_R); mem_ready = 1'($urandom);
      @(posedge clk); @(negedge clk); #1;
      if (illegal !== 1'b1 || instr_ready !== 1'b0 ||
          {alu_src, reg_write, mem_read, mem_write, pc_write} !== 5'd0) bad++;
    end
    chk("trap_hold", bad, 0);
    chk("trap_no_retire", retired_count, cnt);
    rst_n = 1'b0; #1;
    chk("trap_reset_illegal", illegal, 0);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b1;
    run_instr(32'h002081B3, 0);
`else
    run_instr(32'h0000007F, 0);
`endif
  endtask

  task automatic test_wrap();
    force dut.retired_count_q = 16'hFFFE;
    #1;
    release dut.retired_count_q;
    chk("wrap_preload", retired_count, 16'hFFFE);
    run_instr(32'h00500093, 0);
    run_instr(32'h002081B3, 0);
    chk("wrap_to_zero", retired_count, 0);
  endtask

  task automatic test_reset_mid_mem();
    instr_valid = 1'b1; instruction = 32'h00402183; mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_mem_read_before", mem_read, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_mem_read_drop", mem_read, 0);
    chk("mid_mem_count", retired_count, 0);
    chk("mid_mem_ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(32'h002081B3, 1);
    chk("mid_mem_recover_count", retired_count, 1);
  endtask

  task automatic test_back_to_back();
    int kind;
    for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
      kind = $urandom_range(0, 3);
`else
      kind = $urandom_range(0, 4);
`endif
      run_instr(rand_instr(kind), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instruction = 32'd0; mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_sw();
    test_lw();
    test_illegal();
    test_back_to_back();
    test_wrap();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
